quiz_round_ctrl: RTL and testbench

- Round sequencer for the 4-player quiz responder.
- Takes host keys and raw player keys, and runs the round: ready, armed countdown, answer window and result.
- Handles false-start lockout, wrong-answer lockout and re-arm, per-player score keeping, and buzzer pulses.
- Feeds the digit display (Player_Number, Countdown) and LEDs; replaces ad-hoc Block/Timer_Start handling.

---
 rtl/quiz_pkg.sv | 38 +++
 rtl/quiz_key_cond.sv | 68 ++++++
 rtl/quiz_round_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_quiz_round_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quiz_pkg.sv
// Shared types and helpers for the quiz round controller.
// Holds the FSM state codes, player constants and priority helpers.
package quiz_pkg;

  typedef enum logic [2:0] {
    ST_READY  = 3'd0,
    ST_ARMED  = 3'd1,
    ST_ANSWER = 3'd2,
    ST_RESULT = 3'd3
  } state_e;

  localparam logic [3:0] PLAYER_BLANK = 4'd10;
  localparam int         N_PLAYERS    = 4;

  // Keeps only the lowest set bit.
  function automatic logic [3:0] lowest_onehot(
    input logic [3:0] v
  );
    return v & (~v + 4'd1);
  endfunction

  // One-hot player mask to display number 1..4.
  function automatic logic [3:0] onehot_to_num(
    input logic [3:0] oh
  );
    logic [3:0] n;
    n = PLAYER_BLANK;
    unique case (1'b1)
      oh[0]:   n = 4'd1;
      oh[1]:   n = 4'd2;
      oh[2]:   n = 4'd3;
      oh[3]:   n = 4'd4;
      default: n = PLAYER_BLANK;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/quiz_key_cond.sv
// Key conditioner: 2-FF synchronizer, optional debounce
// (KEY_DEBOUNCE_EN), rising-edge one-cycle pulse.
// Ports: i_clk, i_rst_n (async low), i_raw key, o_pulse event.
module quiz_key_cond
`ifdef KEY_DEBOUNCE_EN
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
)
`endif
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_pulse
);

  logic [1:0] r_sync;
  logic       r_prev;
  logic       w_level;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_raw};
    end
  end

`ifdef KEY_DEBOUNCE_EN
  localparam int DW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [DW-1:0] r_cnt;
  logic          r_stable;

  // The filtered level only follows after an unbroken run
  // of the new level; any bounce restarts the run.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (r_sync[1] == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == DB_LAST) begin
      r_cnt    <= '0;
      r_stable <= r_sync[1];
    end else begin
      r_cnt <= r_cnt + DW'(1);
    end
  end

  assign w_level = r_stable;
`else
  assign w_level = r_sync[1];
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_level;
    end
  end

  assign o_pulse = w_level & ~r_prev;

endmodule

// File: rtl/quiz_round_ctrl.sv
// Round sequencer for the 4-player quiz responder.
// In: CLK, RSTn (async low), K[3:0], Host_Start/Correct/Wrong/Clear.
// Out: LED_Out, Player_Number, Countdown, Foul, Score, Buzzer_Enable,
// State. KEY_DEBOUNCE_EN adds DEBOUNCE_CYCLES key filtering.
module quiz_round_ctrl
  import quiz_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 50_000_000,
  parameter int unsigned ARM_SEC     = 10,
  parameter int unsigned ANSWER_SEC  = 20,
  parameter int unsigned SCORE_W     = 4,
  parameter int unsigned BEEP_CYCLES = 25_000_000
`ifdef KEY_DEBOUNCE_EN
  ,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
`endif
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic [3:0]             K,
  input  logic                   Host_Start,
  input  logic                   Host_Correct,
  input  logic                   Host_Wrong,
  input  logic                   Host_Clear,
  output logic [3:0]             LED_Out,
  output logic [3:0]             Player_Number,
  output logic [4:0]             Countdown,
  output logic [3:0]             Foul,
  output logic [4*SCORE_W-1:0]   Score,
  output logic                   Buzzer_Enable,
  output logic [2:0]             State
);

  localparam int TW =
    (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int BW = $clog2(BEEP_CYCLES + 1);
  localparam int SW = N_PLAYERS * SCORE_W;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [BW-1:0] BEEP_LOAD = BW'(BEEP_CYCLES);
  localparam logic [4:0]    CD_ARM    = 5'(ARM_SEC);
  localparam logic [4:0]    CD_ANS    = 5'(ANSWER_SEC);

  logic [7:0] w_raw;
  logic [7:0] w_ev;
  logic [3:0] w_kev;
  logic       w_start;
  logic       w_correct;
  logic       w_wrong;
  logic       w_clear;

  assign w_raw = {Host_Clear, Host_Wrong, Host_Correct,
                  Host_Start, K};

  for (genvar g = 0; g < 8; g++) begin : g_key
    quiz_key_cond
`ifdef KEY_DEBOUNCE_EN
      #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
      u_key (
        .i_clk   (CLK),
        .i_rst_n (RSTn),
        .i_raw   (w_raw[g]),
        .o_pulse (w_ev[g])
      );
  end

  assign w_kev     = w_ev[3:0];
  assign w_start   = w_ev[4];
  assign w_correct = w_ev[5];
  assign w_wrong   = w_ev[6];
  assign w_clear   = w_ev[7];

  state_e        r_state;
  logic [TW-1:0] r_tick;
  logic [4:0]    r_cd;
  logic [3:0]    r_led;
  logic [3:0]    r_pnum;
  logic [3:0]    r_foul;
  logic [SW-1:0] r_score;
  logic [BW-1:0] r_beep;

  state_e        w_state_n;
  logic [TW-1:0] w_tick_n;
  logic [4:0]    w_cd_n;
  logic [3:0]    w_led_n;
  logic [3:0]    w_pnum_n;
  logic [3:0]    w_foul_n;
  logic [SW-1:0] w_score_n;
  logic          w_beep_trig;
  logic          w_live;
  logic          w_wrap;
  logic          w_expire;
  logic [3:0]    w_cand;
  logic [3:0]    w_win;
  logic [3:0]    w_foul_all;

  assign w_live   = (r_state == ST_ARMED) ||
                    (r_state == ST_ANSWER);
  assign w_wrap   = (r_tick == TICK_LAST);
  // Expiry is the tick that would take the countdown to zero.
  assign w_expire = w_live && w_wrap && (r_cd == 5'd1);
  assign w_cand   = w_kev & ~r_foul;
  assign w_win    = lowest_onehot(w_cand);
  assign w_foul_all = r_foul | r_led;

  always_comb begin
    w_state_n   = r_state;
    w_tick_n    = r_tick;
    w_cd_n      = r_cd;
    w_led_n     = r_led;
    w_pnum_n    = r_pnum;
    w_foul_n    = r_foul;
    w_score_n   = r_score;
    w_beep_trig = 1'b0;

    if (w_live) begin
      w_tick_n = w_wrap ? '0 : r_tick + TW'(1);
      w_cd_n   = w_wrap ? r_cd - 5'd1 : r_cd;
    end

    if (w_clear ||
        (w_start && (r_state == ST_RESULT))) begin
      w_state_n = ST_READY;
      w_foul_n  = '0;
      w_led_n   = '0;
      w_pnum_n  = PLAYER_BLANK;
      w_cd_n    = '0;
      w_tick_n  = '0;
    end else begin
      unique case (r_state)
        ST_READY: begin
          // Any press before the window opens is a false start.
          if (|w_kev) begin
            w_foul_n    = r_foul | w_kev;
            w_beep_trig = 1'b1;
          end
          if (w_start) begin
            w_state_n = ST_ARMED;
            w_cd_n    = CD_ARM;
            w_tick_n  = '0;
          end
        end
        ST_ARMED: begin
          if (w_expire) begin
            w_state_n   = ST_RESULT;
            w_pnum_n    = PLAYER_BLANK;
            w_cd_n      = '0;
            w_tick_n    = '0;
            w_beep_trig = 1'b1;
          end else if (|w_cand) begin
            w_state_n   = ST_ANSWER;
            w_led_n     = w_win;
            w_pnum_n    = onehot_to_num(w_win);
            w_cd_n      = CD_ANS;
            w_tick_n    = '0;
            w_beep_trig = 1'b1;
          end
        end
        ST_ANSWER: begin
          if (w_correct) begin
            for (int i = 0; i < N_PLAYERS; i++) begin
              if (r_led[i] &&
                  (r_score[i*SCORE_W +: SCORE_W] !=
                   {SCORE_W{1'b1}})) begin
                w_score_n[i*SCORE_W +: SCORE_W] =
                  r_score[i*SCORE_W +: SCORE_W] + SCORE_W'(1);
              end
            end
            w_state_n = ST_RESULT;
            w_cd_n    = '0;
            w_tick_n  = '0;
          end else if (w_wrong || w_expire) begin
            w_foul_n = w_foul_all;
            w_led_n  = '0;
            w_pnum_n = PLAYER_BLANK;
            w_tick_n = '0;
            if (w_foul_all != 4'hF) begin
              w_state_n = ST_ARMED;
              w_cd_n    = CD_ARM;
            end else begin
              w_state_n = ST_RESULT;
              w_cd_n    = '0;
            end
          end
        end
        ST_RESULT: begin
          w_cd_n = '0;
        end
        default: begin
          w_state_n = ST_READY;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= ST_READY;
      r_tick  <= '0;
      r_cd    <= '0;
      r_led   <= '0;
      r_pnum  <= PLAYER_BLANK;
      r_foul  <= '0;
      r_score <= '0;
      r_beep  <= '0;
    end else begin
      r_state <= w_state_n;
      r_tick  <= w_tick_n;
      r_cd    <= w_cd_n;
      r_led   <= w_led_n;
      r_pnum  <= w_pnum_n;
      r_foul  <= w_foul_n;
      r_score <= w_score_n;
      if (w_beep_trig) begin
        r_beep <= BEEP_LOAD;
      end else if (r_beep != '0) begin
        r_beep <= r_beep - BW'(1);
      end
    end
  end

  assign LED_Out       = r_led;
  assign Player_Number = r_pnum;
  assign Countdown     = r_cd;
  assign Foul          = r_foul;
  assign Score         = r_score;
  assign Buzzer_Enable = (r_beep != '0);
  assign State         = r_state;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Bench for quiz_round_ctrl: behavioural round model checked
// every cycle, directed scenarios with literal expectations, random.
module tb_quiz_round_ctrl;

  localparam int TICK = 4;
  localparam int ARM  = 3;
  localparam int ANS  = 2;
  localparam int BEEP = 3;
  localparam int SW   = 2;
  localparam int SMAX = 3;

  logic       CLK  = 1'b0;
  logic       RSTn = 1'b0;
  logic [7:0] raw  = 8'h00;

  logic [3:0]      LED_Out;
  logic [3:0]      Player_Number;
  logic [4:0]      Countdown;
  logic [3:0]      Foul;
  logic [4*SW-1:0] Score;
  logic            Buzzer_Enable;
  logic [2:0]      State;

  always #5 CLK = ~CLK;

  quiz_round_ctrl #(
    .TICK_CYCLES (TICK),
    .ARM_SEC     (ARM),
    .ANSWER_SEC  (ANS),
    .SCORE_W     (SW),
    .BEEP_CYCLES (BEEP)
  ) dut (
    .CLK           (CLK),
    .RSTn          (RSTn),
    .K             (raw[3:0]),
    .Host_Start    (raw[4]),
    .Host_Correct  (raw[5]),
    .Host_Wrong    (raw[6]),
    .Host_Clear    (raw[7]),
    .LED_Out       (LED_Out),
    .Player_Number (Player_Number),
    .Countdown     (Countdown),
    .Foul          (Foul),
    .Score         (Score),
    .Buzzer_Enable (Buzzer_Enable),
    .State         (State)
  );

  int checks = 0;
  int errors = 0;

  // Model: phase 0..3, elapsed cycles in the open window,
  // winner index (-1 none), per-player scores, beep cycles left.
  int         m_phase;
  int         m_e;
  int         m_win;
  int         m_beep;
  logic [3:0] m_foul;
  int         m_sc [4];
  logic [7:0] h0, h1, h2;

  task automatic model_reset();
    m_phase = 0; m_e = 0; m_win = -1; m_beep = 0;
    m_foul = 4'h0;
    for (int i = 0; i < 4; i++) m_sc[i] = 0;
    h0 = 8'h00; h1 = 8'h00; h2 = 8'h00;
  endtask

  task automatic model_step(input logic [7:0] rnow);
    logic [7:0] ev;
    logic [3:0] kev;
    bit         st, co, wr, cl, expire, trig;
    int         lim, wi;
    // A raw rise acts on the third clock edge that sees it.
    ev = h1 & ~h2;
    h2 = h1; h1 = h0; h0 = rnow;
    kev = ev[3:0];
    st = ev[4]; co = ev[5]; wr = ev[6]; cl = ev[7];
    trig = 0;
    wi = -1;
    lim = (m_phase == 1) ? ARM * TICK : ANS * TICK;
    expire = (m_phase == 1 || m_phase == 2) && (m_e == lim - 1);
    if (cl || (st && m_phase == 3)) begin
      m_phase = 0; m_foul = 4'h0; m_win = -1; m_e = 0;
    end else if (m_phase == 0) begin
      if (kev != 4'h0) begin
        m_foul = m_foul | kev;
        trig = 1;
      end
      if (st) begin
        m_phase = 1; m_e = 0;
      end
    end else if (m_phase == 1) begin
      m_e++;
      if (expire) begin
        m_phase = 3; m_e = 0; trig = 1;
      end else begin
        for (int i = 3; i >= 0; i--)
          if (kev[i] && !m_foul[i]) wi = i;
        if (wi >= 0) begin
          m_win = wi; m_phase = 2; m_e = 0; trig = 1;
        end
      end
    end else if (m_phase == 2) begin
      m_e++;
      if (co) begin
        if (m_sc[m_win] < SMAX) m_sc[m_win]++;
        m_phase = 3; m_e = 0;
      end else if (wr || expire) begin
        m_foul[m_win] = 1'b1;
        m_win = -1; m_e = 0;
        m_phase = (m_foul != 4'hF) ? 1 : 3;
      end
    end
    if (trig) m_beep = BEEP;
    else if (m_beep > 0) m_beep--;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    logic [3:0]      e_led, e_pn;
    logic [4:0]      e_cd;
    logic [4*SW-1:0] e_sc;
    e_led = (m_win >= 0) ? 4'(1 << m_win) : 4'h0;
    e_pn  = (m_win >= 0) ? 4'(m_win + 1) : 4'd10;
    if (m_phase == 1)      e_cd = 5'(ARM - m_e / TICK);
    else if (m_phase == 2) e_cd = 5'(ANS - m_e / TICK);
    else                   e_cd = 5'd0;
    for (int i = 0; i < 4; i++) e_sc[i*SW +: SW] = SW'(m_sc[i]);
    chk("m_led",   32'(LED_Out),       32'(e_led));
    chk("m_pnum",  32'(Player_Number), 32'(e_pn));
    chk("m_cd",    32'(Countdown),     32'(e_cd));
    chk("m_foul",  32'(Foul),          32'(m_foul));
    chk("m_score", 32'(Score),         32'(e_sc));
    chk("m_buzz",  32'(Buzzer_Enable), 32'(m_beep > 0));
    chk("m_state", 32'(State),         32'(m_phase));
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK or negedge RSTn);
      if (!RSTn) model_reset();
      else model_step(raw);
    end
  end

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      cmp_model();
    end
  end

  // One-cycle raw press, then wait until its action is visible.
  task automatic act(input logic [7:0] v);
    raw = v;
    @(negedge CLK);
    raw = 8'h00;
    repeat (2) @(negedge CLK);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_led"},   32'(LED_Out),       32'h0);
    chk({nm, "_pnum"},  32'(Player_Number), 32'd10);
    chk({nm, "_cd"},    32'(Countdown),     32'd0);
    chk({nm, "_foul"},  32'(Foul),          32'h0);
    chk({nm, "_score"}, 32'(Score),         32'h0);
    chk({nm, "_buzz"},  32'(Buzzer_Enable), 32'd0);
    chk({nm, "_state"}, 32'(State),         32'd0);
  endtask

  int kr;

  initial begin
    RSTn = 1'b0;
    raw  = 8'h00;
    repeat (3) @(negedge CLK);
    chk_reset_vals("rst");
    RSTn = 1'b1;
    @(negedge CLK);

    // Simultaneous presses resolve to the lower index.
    act(8'h10);
    chk("t1_arm_state", 32'(State), 32'd1);
    chk("t1_arm_cd", 32'(Countdown), 32'd3);
    act(8'h06);
    chk("t1_pnum", 32'(Player_Number), 32'd2);
    chk("t1_led", 32'(LED_Out), 32'h2);
    chk("t1_state", 32'(State), 32'd2);
    chk("t1_cd", 32'(Countdown), 32'd2);
    act(8'h20);
    chk("t1_score", 32'(Score), 32'h04);
    chk("t1_result", 32'(State), 32'd3);

    // False start, then fouled player ignored.
    act(8'h80);
    chk("t2_ready", 32'(State), 32'd0);
    act(8'h01);
    chk("t2_foul", 32'(Foul), 32'h1);
    chk("t2_buzz_on", 32'(Buzzer_Enable), 32'd1);
    repeat (2) @(negedge CLK);
    chk("t2_buzz_3rd", 32'(Buzzer_Enable), 32'd1);
    @(negedge CLK);
    chk("t2_buzz_off", 32'(Buzzer_Enable), 32'd0);
    act(8'h10);
    act(8'h01);
    chk("t2_ignored_st", 32'(State), 32'd1);
    chk("t2_ignored_pn", 32'(Player_Number), 32'd10);
    act(8'h04);
    chk("t2_pnum", 32'(Player_Number), 32'd3);
    chk("t2_led", 32'(LED_Out), 32'h4);

    // Wrong answer re-arms, then the armed window runs out.
    act(8'h80);
    act(8'h10);
    act(8'h01);
    chk("t3_pnum", 32'(Player_Number), 32'd1);
    act(8'h40);
    chk("t3_foul", 32'(Foul), 32'h1);
    chk("t3_state", 32'(State), 32'd1);
    chk("t3_cd", 32'(Countdown), 32'd3);
    chk("t3_pn_blank", 32'(Player_Number), 32'd10);
    repeat (11) @(negedge CLK);
    chk("t3_last_sec", 32'(Countdown), 32'd1);
    chk("t3_still_arm", 32'(State), 32'd1);
    @(negedge CLK);
    chk("t3_expired", 32'(State), 32'd3);
    chk("t3_exp_pn", 32'(Player_Number), 32'd10);

    // Answer window timeout fouls the answering player.
    act(8'h80);
    act(8'h10);
    act(8'h08);
    chk("t4_pnum", 32'(Player_Number), 32'd4);
    repeat (7) @(negedge CLK);
    chk("t4_still_ans", 32'(State), 32'd2);
    @(negedge CLK);
    chk("t4_foul", 32'(Foul), 32'h8);
    chk("t4_state", 32'(State), 32'd1);
    chk("t4_led", 32'(LED_Out), 32'h0);

    // Score saturation.
    for (int r = 0; r < 4; r++) begin
      act(8'h80);
      act(8'h10);
      act(8'h01);
      act(8'h20);
    end
    chk("t5_sat", 32'(Score), 32'h07);

    // Host_Clear in ANSWER keeps scores.
    act(8'h80);
    act(8'h02);
    chk("t6_foul2", 32'(Foul), 32'h2);
    act(8'h10);
    act(8'h01);
    chk("t6_ans", 32'(State), 32'd2);
    act(8'h80);
    chk("t6_foul0", 32'(Foul), 32'h0);
    chk("t6_score", 32'(Score), 32'h07);
    chk("t6_state", 32'(State), 32'd0);
    chk("t6_pn", 32'(Player_Number), 32'd10);

    // Reset mid-ANSWER.
    act(8'h10);
    act(8'h04);
    chk("t7_ans", 32'(State), 32'd2);
    RSTn = 1'b0;
    #1;
    chk_reset_vals("t7_rst");
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);

    // Random phase, alternating busy and quiet key segments.
    for (int seg = 0; seg < 8; seg++) begin
      kr = (seg % 2 == 0) ? 5 : 40;
      for (int c = 0; c < 400; c++) begin
        raw[3:0] = 4'h0;
        for (int b = 0; b < 4; b++)
          raw[b] = ($urandom_range(0, kr) == 0);
        raw[4] = ($urandom_range(0, 7) == 0);
        raw[5] = ($urandom_range(0, 9) == 0);
        raw[6] = ($urandom_range(0, 9) == 0);
        raw[7] = ($urandom_range(0, 59) == 0);
        if (seg == 5 && c == 200) RSTn = 1'b0;
        if (seg == 5 && c == 202) RSTn = 1'b1;
        @(negedge CLK);
      end
    end
    raw = 8'h00;
    repeat (5) @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
